unit_rd_tracker: RTL and testbench
==================================

// Module: unit_rd_tracker
// PURPOSE
//  Per-unit in-flight destination tracker for the multi-cycle execute units (unit 0 = integer div, 1..N-1 = FP).
//  Records rd/type on issue and frees the entry when the result reaches MEM. Drives the rd_used / busy vectors
//  consumed by the WAW clear logic. Takes back its clear_rd pulses as kill marks; emits RAW stall and writeback-kill.
// PARAMETERS
//  NUM_UNITS      9   number of tracked execute units (index 0 integer, others FP)
//  RD_ADDR_WIDTH  5   register address width
// PORTS
//  clk            in   1                      clock, all state updates on rising edge
//  reset          in   1                      asynchronous, active-high reset
//  issue_valid    in   1                      instruction dispatched this cycle
//  issue_unit     in   NUM_UNITS              one-hot target unit (ignored unless issue_valid)
//  issue_rd       in   RD_ADDR_WIDTH          destination of issuing instruction
//  issue_reg_write in  1                      issuing instr writes integer RF
//  issue_fp_write in   1                      issuing instr writes FP RF
//  unit_done      in   NUM_UNITS              result of unit i reaches MEM this cycle (1-cycle pulse)
//  clear_rd       in   NUM_UNITS              WAW kill request per unit from clear decoder
//  chk_rs1/2/3    in   RD_ADDR_WIDTH each     sources of instruction in decode
//  chk_rs_fp      in   3                      [k]=1: rs(k+1) reads FP RF; [2] only meaningful if chk_r4
//  chk_r4         in   1                      decode instr is R4 (rs3 live)
//  issue_ready    out  NUM_UNITS              unit i can accept an issue this cycle
//  rd_used        out  RD_ADDR_WIDTH x NUM_UNITS  unpacked [0:NUM_UNITS-1], stored rd per unit
//  all_uu_rd_busy out  NUM_UNITS              entry holds a live (unkilled, real) destination
//  raw_stall      out  1                      a live source in decode matches a live entry of same RF type
//  wb_kill        out  NUM_UNITS              suppress RF write for unit i (valid with unit_done[i])
// BEHAVIOUR
//  Reset: all entries occ=0, live=0, killed=0, rd=0, fp=0 -> rd_used all 0, busy 0, raw_stall 0, wb_kill 0,
//   issue_ready all 1. Reset mid-flight discards everything; later unit_done pulses are ignored when occ=0.
//  Entry fields: occ, live, killed, fp, rd. Per-unit 2-state FSM FREE <-> OCC.
//  FREE->OCC: issue_valid & issue_unit[i]. Latch rd, fp=issue_fp_write, killed=0,
//   live = (issue_fp_write) | (issue_reg_write & issue_rd!=0). Visible on outputs next cycle (1-cycle latency).
//  OCC->FREE: unit_done[i] with no same-cycle issue to i. occ/live/killed <= 0; rd retained (don't care).
//  OCC & unit_done[i] & issue to i same cycle: new issue wins, entry reloaded, stays OCC (back-to-back).
//  issue_ready[i] = ~occ[i] | unit_done[i]. Issue to a unit with issue_ready=0 is a protocol error:
//   entry unchanged; SVA assertion fires.
//  clear_rd[i] while OCC: killed<=1 (sticky until free). live & killed entries are excluded from busy/RAW.
//  clear_rd[i] with unit_done[i] same cycle: wb_kill[i]=1 that cycle (combinational from clear_rd | killed).
//  clear_rd[i] while FREE: ignored.
//  wb_kill[i] = unit_done[i] & occ[i] & (killed[i] | clear_rd[i]); 0 otherwise.
//  all_uu_rd_busy[i] = occ & live & ~killed (registered fields, combinational AND).
//  raw_stall: OR over i of all_uu_rd_busy[i] & fp[i]==type(rsk) & rd[i]==rsk for k=1,2, and k=3 iff chk_r4.
//   An integer source x0 never matches (integer entries with rd=0 are never live).
//   Entry freeing via unit_done in current cycle still counts (no MEM->decode bypass assumed here).
//  Integer rd / FP rd with same index are distinct: no cross-type matches.
// STRUCTURE
//  raw_waw_pkg: NUM_EXE_UNITS, RD_ADDR_W, typedef unit_entry_t {occ,live,killed,fp,rd}, UNIT_INT_DIV=0.
//  Sub-module unit_rd_entry: one FSM/entry per unit (generate loop); top holds RAW compare OR-tree and outputs.
// TESTING
//  1 reset mid-flight: issue unit2 rd=f5, assert reset -> next cycle busy=0, rd_used[2]=0, issue_ready=all 1.
//  2 issue div x0 (int, rd=0) -> occ=1, busy[0]=0, chk_rs1=0 int -> raw_stall=0; issue_ready[0]=0 until done.
//  3 issue unit3 rd=f7 fp; decode fadd rs1=f7 fp -> raw_stall=1; same rs1=7 int -> 0; after done[3] -> 0.
//  4 issue unit1 rd=f4, clear_rd[1] pulse -> busy[1]=0 next cycle; later done[1] -> wb_kill[1]=1, entry free.
//  5 done[4] & clear_rd[4] same cycle -> wb_kill[4]=1 that cycle; done[4] alone on clean entry -> wb_kill=0.
//  6 done[5] & issue unit5 rd=f9 same cycle -> occ stays 1, rd_used[5]=9, killed=0, issue_ready[5]=0 next cycle.

Source files
------------

// File: rtl/raw_waw_pkg.sv
// Shared definitions for the in-flight destination tracker of the
// multi-cycle execute units. Unit 0 is the integer divider, every other
// unit is floating point.
//
// Contents:
//   NUM_EXE_UNITS  default number of tracked execute units
//   RD_ADDR_W      register address width
//   UNIT_INT_DIV   index of the integer divide unit
//   unit_entry_t   per-unit record {occ, live, killed, fp, rd}
package raw_waw_pkg;

    localparam int NUM_EXE_UNITS = 9;
    localparam int RD_ADDR_W     = 5;
    localparam int UNIT_INT_DIV  = 0;

    // occ    : unit holds an issued instruction that has not reached MEM
    // live   : that instruction really writes a register (FP write, or
    //          integer write to a non-x0 destination)
    // killed : a younger writer to the same rd made this result dead
    // fp     : destination lives in the FP register file
    // rd     : destination register index
    typedef struct packed {
        logic                 occ;
        logic                 live;
        logic                 killed;
        logic                 fp;
        logic [RD_ADDR_W-1:0] rd;
    } unit_entry_t;

endpackage

// File: rtl/unit_rd_entry.sv
// One tracker entry: a FREE/OCC state machine for a single execute unit.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   issue_i             instruction dispatched to this unit this cycle
//   issue_rd_i          destination of the dispatched instruction
//   issue_reg_write_i   dispatched instruction writes the integer RF
//   issue_fp_write_i    dispatched instruction writes the FP RF
//   done_i              this unit's result reaches MEM this cycle
//   clear_i             WAW kill request for this unit
//   entry_o             registered entry record (occ doubles as FSM state)
//   ready_o             unit can accept an issue this cycle
//   wb_kill_o           suppress the RF write of the result leaving now
//
// Handshake: an issue is taken only when issue_i and ready_o are both high
// in the same cycle; ready_o is high when the entry is free or is freeing
// this cycle. An issue while ready_o is low leaves the entry untouched.
module unit_rd_entry
    import raw_waw_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_i,
    input  logic [RD_ADDR_W-1:0] issue_rd_i,
    input  logic                 issue_reg_write_i,
    input  logic                 issue_fp_write_i,
    input  logic                 done_i,
    input  logic                 clear_i,
    output unit_entry_t          entry_o,
    output logic                 ready_o,
    output logic                 wb_kill_o
);

    localparam logic STATE_FREE = 1'b0;
    localparam logic STATE_OCC  = 1'b1;

    logic                 state_q, state_d;
    logic                 live_q, live_d;
    logic                 killed_q, killed_d;
    logic                 fp_q, fp_d;
    logic [RD_ADDR_W-1:0] rd_q, rd_d;

    logic occ;
    logic accept;

    assign occ     = (state_q == STATE_OCC);
    assign ready_o = ~occ | done_i;
    assign accept  = issue_i & ready_o;

    always_comb begin
        state_d  = state_q;
        live_d   = live_q;
        killed_d = killed_q;
        fp_d     = fp_q;
        rd_d     = rd_q;
        if (accept) begin
            // A same-cycle done on an occupied entry is overridden here:
            // the new instruction reloads the entry (back-to-back issue).
            state_d  = STATE_OCC;
            rd_d     = issue_rd_i;
            fp_d     = issue_fp_write_i;
            killed_d = 1'b0;
            // Integer writes to x0 are architecturally discarded, so they
            // never hold a live destination.
            live_d   = issue_fp_write_i | (issue_reg_write_i & (|issue_rd_i));
        end else begin
            case (state_q)
                STATE_OCC: begin
                    if (done_i) begin
                        state_d  = STATE_FREE;
                        live_d   = 1'b0;
                        killed_d = 1'b0;
                    end else if (clear_i) begin
                        killed_d = 1'b1;
                    end
                end
                default: begin
                    state_d = STATE_FREE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= STATE_FREE;
            live_q   <= 1'b0;
            killed_q <= 1'b0;
            fp_q     <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            live_q   <= live_d;
            killed_q <= killed_d;
            fp_q     <= fp_d;
            rd_q     <= rd_d;
        end
    end

    // A kill arriving in the same cycle as the result still suppresses it.
    assign wb_kill_o = done_i & occ & (killed_q | clear_i);

    assign entry_o = '{occ: occ, live: live_q, killed: killed_q, fp: fp_q, rd: rd_q};

endmodule

// File: rtl/unit_rd_tracker.sv
// Per-unit in-flight destination tracker for the multi-cycle execute
// units. Records rd/type at issue, frees the entry when the result reaches
// MEM, publishes rd_used/busy for the WAW clear logic, accepts clear_rd
// back as kill marks and produces the RAW stall and writeback kill.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   issue_valid       instruction dispatched this cycle
//   issue_unit        one-hot target unit
//   issue_rd          destination of the issuing instruction
//   issue_reg_write   issuing instruction writes the integer RF
//   issue_fp_write    issuing instruction writes the FP RF
//   unit_done         result of unit i reaches MEM this cycle
//   clear_rd          WAW kill request per unit
//   chk_rs1/2/3       sources of the instruction in decode
//   chk_rs_fp         [k]=1: source k+1 reads the FP RF
//   chk_r4            decode instruction is R4 (rs3 live)
//   issue_ready       unit i can accept an issue this cycle
//   rd_used           stored destination per unit
//   all_uu_rd_busy    entry holds a live, unkilled destination
//   raw_stall         a live decode source matches a busy entry of same RF
//   wb_kill           suppress RF write of unit i (qualified by unit_done)
//
// Handshake: unit i accepts an issue when issue_valid, issue_unit[i] and
// issue_ready[i] are high together; issuing to a non-ready unit is a
// protocol error that leaves the entry unchanged.
module unit_rd_tracker
    import raw_waw_pkg::*;
#(
    parameter int NUM_UNITS     = NUM_EXE_UNITS,
    // Entry records carry RD_ADDR_W bits; keep this equal to it.
    parameter int RD_ADDR_WIDTH = RD_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [NUM_UNITS-1:0]     issue_unit,
    input  logic [RD_ADDR_WIDTH-1:0] issue_rd,
    input  logic                     issue_reg_write,
    input  logic                     issue_fp_write,
    input  logic [NUM_UNITS-1:0]     unit_done,
    input  logic [NUM_UNITS-1:0]     clear_rd,
    input  logic [RD_ADDR_WIDTH-1:0] chk_rs1,
    input  logic [RD_ADDR_WIDTH-1:0] chk_rs2,
    input  logic [RD_ADDR_WIDTH-1:0] chk_rs3,
    input  logic [2:0]               chk_rs_fp,
    input  logic                     chk_r4,
    output logic [NUM_UNITS-1:0]     issue_ready,
    output logic [RD_ADDR_WIDTH-1:0] rd_used [0:NUM_UNITS-1],
    output logic [NUM_UNITS-1:0]     all_uu_rd_busy,
    output logic                     raw_stall,
    output logic [NUM_UNITS-1:0]     wb_kill
);

    unit_entry_t entry [0:NUM_UNITS-1];

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_entry
        unit_rd_entry u_entry (
            .clk               (clk),
            .reset             (reset),
            .issue_i           (issue_valid & issue_unit[i]),
            .issue_rd_i        (issue_rd),
            .issue_reg_write_i (issue_reg_write),
            .issue_fp_write_i  (issue_fp_write),
            .done_i            (unit_done[i]),
            .clear_i           (clear_rd[i]),
            .entry_o           (entry[i]),
            .ready_o           (issue_ready[i]),
            .wb_kill_o         (wb_kill[i])
        );

        assign rd_used[i]        = entry[i].rd;
        assign all_uu_rd_busy[i] = entry[i].occ & entry[i].live & ~entry[i].killed;
    end

    // An entry freeing this cycle still stalls: there is no MEM->decode
    // bypass, so the consumer must wait one more cycle for the RF write.
    always_comb begin
        raw_stall = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (all_uu_rd_busy[i]) begin
                if ((entry[i].fp == chk_rs_fp[0]) && (entry[i].rd == chk_rs1)) raw_stall = 1'b1;
                if ((entry[i].fp == chk_rs_fp[1]) && (entry[i].rd == chk_rs2)) raw_stall = 1'b1;
                if (chk_r4 && (entry[i].fp == chk_rs_fp[2]) && (entry[i].rd == chk_rs3)) raw_stall = 1'b1;
            end
        end
    end

    a_issue_to_ready: assert property (@(posedge clk) disable iff (reset)
        issue_valid |-> ((issue_unit & ~issue_ready) == '0));

    a_issue_onehot: assert property (@(posedge clk) disable iff (reset)
        issue_valid |-> $onehot(issue_unit));

    a_div_is_integer: assert property (@(posedge clk) disable iff (reset)
        (issue_valid & issue_unit[UNIT_INT_DIV]) |-> !issue_fp_write);

endmodule

// File: tb/tb_unit_rd_tracker.sv
module tb_unit_rd_tracker;
    import raw_waw_pkg::*;

    localparam int N = NUM_EXE_UNITS;
    localparam int W = RD_ADDR_W;

    logic         clk = 1'b0;
    logic         reset;
    logic         issue_valid;
    logic [N-1:0] issue_unit;
    logic [W-1:0] issue_rd;
    logic         issue_reg_write;
    logic         issue_fp_write;
    logic [N-1:0] unit_done;
    logic [N-1:0] clear_rd;
    logic [W-1:0] chk_rs1, chk_rs2, chk_rs3;
    logic [2:0]   chk_rs_fp;
    logic         chk_r4;
    logic [N-1:0] issue_ready;
    logic [W-1:0] rd_used [0:N-1];
    logic [N-1:0] all_uu_rd_busy;
    logic         raw_stall;
    logic [N-1:0] wb_kill;

    unit_rd_tracker dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_unit      (issue_unit),
        .issue_rd        (issue_rd),
        .issue_reg_write (issue_reg_write),
        .issue_fp_write  (issue_fp_write),
        .unit_done       (unit_done),
        .clear_rd        (clear_rd),
        .chk_rs1         (chk_rs1),
        .chk_rs2         (chk_rs2),
        .chk_rs3         (chk_rs3),
        .chk_rs_fp       (chk_rs_fp),
        .chk_r4          (chk_r4),
        .issue_ready     (issue_ready),
        .rd_used         (rd_used),
        .all_uu_rd_busy  (all_uu_rd_busy),
        .raw_stall       (raw_stall),
        .wb_kill         (wb_kill)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // One record per unit describing the instruction it is executing.
    bit           m_inflight [N];
    bit           m_writes   [N];
    bit           m_killed   [N];
    bit           m_fp       [N];
    logic [W-1:0] m_rd       [N];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_inflight[i] = 0;
            m_writes[i]   = 0;
            m_killed[i]   = 0;
            m_fp[i]       = 0;
            m_rd[i]       = '0;
        end
    endfunction

    function automatic bit model_ready(input int u);
        return !m_inflight[u] || unit_done[u];
    endfunction

    function automatic bit model_busy(input int u);
        return m_inflight[u] && m_writes[u] && !m_killed[u];
    endfunction

    // A decode source stalls when some unit will still write that very
    // register (same index, same register file) and has not been killed.
    function automatic bit model_raw();
        logic [W-1:0] src_addr [$];
        bit           src_fp   [$];
        src_addr.push_back(chk_rs1); src_fp.push_back(chk_rs_fp[0]);
        src_addr.push_back(chk_rs2); src_fp.push_back(chk_rs_fp[1]);
        if (chk_r4) begin
            src_addr.push_back(chk_rs3); src_fp.push_back(chk_rs_fp[2]);
        end
        for (int s = 0; s < src_addr.size(); s++)
            for (int u = 0; u < N; u++)
                if (model_busy(u) && m_fp[u] == src_fp[s] && m_rd[u] == src_addr[s])
                    return 1;
        return 0;
    endfunction

    function automatic void model_update();
        for (int u = 0; u < N; u++) begin
            if (issue_valid && issue_unit[u] && model_ready(u)) begin
                m_inflight[u] = 1;
                m_rd[u]       = issue_rd;
                m_fp[u]       = issue_fp_write;
                m_killed[u]   = 0;
                m_writes[u]   = issue_fp_write || (issue_reg_write && issue_rd != 0);
            end else if (m_inflight[u] && unit_done[u]) begin
                m_inflight[u] = 0;
                m_writes[u]   = 0;
                m_killed[u]   = 0;
            end else if (m_inflight[u] && clear_rd[u]) begin
                m_killed[u] = 1;
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_outputs(input string tag);
        logic [N-1:0] e_busy, e_ready, e_kill;
        for (int u = 0; u < N; u++) begin
            e_busy[u]  = model_busy(u);
            e_ready[u] = model_ready(u);
            e_kill[u]  = unit_done[u] && m_inflight[u] && (m_killed[u] || clear_rd[u]);
        end
        check_eq({tag, ":busy"},  32'(all_uu_rd_busy), 32'(e_busy));
        check_eq({tag, ":ready"}, 32'(issue_ready),    32'(e_ready));
        check_eq({tag, ":wbk"},   32'(wb_kill),        32'(e_kill));
        check_eq({tag, ":raw"},   32'(raw_stall),      32'(model_raw()));
        for (int u = 0; u < N; u++)
            check_eq($sformatf("%s:rd_used%0d", tag, u), 32'(rd_used[u]), 32'(m_rd[u]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        issue_valid     = 0;
        issue_unit      = '0;
        issue_rd        = '0;
        issue_reg_write = 0;
        issue_fp_write  = 0;
        unit_done       = '0;
        clear_rd        = '0;
        chk_rs1         = '0;
        chk_rs2         = '0;
        chk_rs3         = '0;
        chk_rs_fp       = '0;
        chk_r4          = 0;
    endtask

    task automatic issue(input int u, input int rd, input bit reg_w, input bit fp_w);
        issue_valid     = 1;
        issue_unit      = N'(1) << u;
        issue_rd        = W'(rd);
        issue_reg_write = reg_w;
        issue_fp_write  = fp_w;
    endtask

    // Inputs are driven just after the falling edge; outputs are checked
    // 1 ns later, then the model advances with the rising edge.
    task automatic cycle(input string tag);
        #1;
        check_outputs(tag);
        @(posedge clk);
        if (!reset) model_update();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1;
        idle();
        model_clear();
        #1;
        check_outputs("rst");
        @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1;
        idle();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_busy",  32'(all_uu_rd_busy), 32'(0));
        check_eq("rst_ready", 32'(issue_ready),    32'({N{1'b1}}));
        check_eq("rst_wbk",   32'(wb_kill),        32'(0));
        @(negedge clk);
        reset = 0;

        // 1: reset while an instruction is in flight
        issue(2, 5, 0, 1);
        cycle("t1_issue");
        idle();
        #1;
        check_eq("t1_busy2", 32'(all_uu_rd_busy[2]), 32'(1));
        apply_reset();
        idle();
        #1;
        check_eq("t1_busy_after_rst",  32'(all_uu_rd_busy), 32'(0));
        check_eq("t1_rd2_after_rst",   32'(rd_used[2]),     32'(0));
        check_eq("t1_ready_after_rst", 32'(issue_ready),    32'({N{1'b1}}));
        cycle("t1_post");

        // 2: divide to x0 never becomes busy
        issue(UNIT_INT_DIV, 0, 1, 0);
        cycle("t2_issue");
        idle();
        #1;
        check_eq("t2_busy0",  32'(all_uu_rd_busy[0]), 32'(0));
        check_eq("t2_raw_x0", 32'(raw_stall),          32'(0));
        check_eq("t2_ready0", 32'(issue_ready[0]),     32'(0));
        cycle("t2_wait");
        unit_done[0] = 1;
        cycle("t2_done");
        idle();
        #1;
        check_eq("t2_ready0_free", 32'(issue_ready[0]), 32'(1));

        // 3: FP RAW on f7; integer x7 does not match
        issue(3, 7, 0, 1);
        cycle("t3_issue");
        idle();
        chk_rs1 = 7; chk_rs_fp = 3'b001;
        #1;
        check_eq("t3_raw_fp", 32'(raw_stall), 32'(1));
        cycle("t3_a");
        chk_rs1 = 7; chk_rs_fp = 3'b000;
        #1;
        check_eq("t3_raw_int", 32'(raw_stall), 32'(0));
        chk_rs_fp = 3'b001; unit_done[3] = 1;
        cycle("t3_done");
        idle();
        chk_rs1 = 7; chk_rs_fp = 3'b001;
        #1;
        check_eq("t3_raw_freed", 32'(raw_stall), 32'(0));
        cycle("t3_b");

        // 4: kill mark then done -> writeback suppressed
        idle();
        issue(1, 4, 0, 1);
        cycle("t4_issue");
        idle();
        clear_rd[1] = 1;
        cycle("t4_clear");
        idle();
        #1;
        check_eq("t4_busy1", 32'(all_uu_rd_busy[1]), 32'(0));
        unit_done[1] = 1;
        #1;
        check_eq("t4_wbk1", 32'(wb_kill[1]), 32'(1));
        cycle("t4_done");
        idle();
        #1;
        check_eq("t4_ready1", 32'(issue_ready[1]), 32'(1));

        // 5: kill in the same cycle as done; then a clean done
        issue(4, 11, 0, 1);
        cycle("t5_issue");
        idle();
        unit_done[4] = 1; clear_rd[4] = 1;
        #1;
        check_eq("t5_wbk_same", 32'(wb_kill[4]), 32'(1));
        cycle("t5_done_kill");
        idle();
        issue(4, 12, 0, 1);
        cycle("t5_issue2");
        idle();
        unit_done[4] = 1;
        #1;
        check_eq("t5_wbk_clean", 32'(wb_kill[4]), 32'(0));
        cycle("t5_done_clean");

        // 6: back-to-back done + issue on the same unit
        idle();
        issue(5, 3, 0, 1);
        cycle("t6_issue");
        issue(5, 9, 0, 1);
        unit_done[5] = 1;
        cycle("t6_b2b");
        idle();
        #1;
        check_eq("t6_rd5",    32'(rd_used[5]),         32'(9));
        check_eq("t6_busy5",  32'(all_uu_rd_busy[5]),  32'(1));
        check_eq("t6_ready5", 32'(issue_ready[5]),     32'(0));
        unit_done[5] = 1;
        cycle("t6_drain");

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            if (c == 300) apply_reset();
            for (int u = 0; u < N; u++) begin
                if (m_inflight[u]) unit_done[u] = ($urandom_range(0, 3) == 0);
                else               unit_done[u] = ($urandom_range(0, 15) == 0);
                clear_rd[u] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 1) == 1) begin
                int u;
                u = $urandom_range(0, N - 1);
                if (model_ready(u))
                    issue(u, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                          (u == UNIT_INT_DIV) ? 1'b0 : 1'($urandom_range(0, 1)));
            end else begin
                issue_unit = N'($urandom_range(0, (1 << N) - 1));
            end
            chk_rs1   = W'($urandom_range(0, 7));
            chk_rs2   = W'($urandom_range(0, 7));
            chk_rs3   = W'($urandom_range(0, 7));
            chk_rs_fp = 3'($urandom_range(0, 7));
            chk_r4    = 1'($urandom_range(0, 1));
            cycle("rnd");
        end

        idle();
        cycle("end");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
